riscv_fetch_stage: RTL and testbench

Instruction-fetch front end of the pipelined RISC-V core inside the TinyTapeout top. It owns the PC, issues in-order requests to the instruction memory through a valid/ready port, and buffers returned words with their PCs in a small FIFO. It presents {pc, instr} to the decode stage through a valid/ready handshake. Branch/jump redirects from execute flush all fetched and in-flight instructions.

---
 rtl/riscv_fetch_stage.sv | 126 ++++++++++++
 tb/tb_riscv_fetch_stage.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/riscv_fetch_stage.sv
// Instruction fetch front end: owns the PC and issues in-order imem requests.
// Returned words are queued with their PCs and handed to decode over valid/ready.
module riscv_fetch_stage #(
  parameter int unsigned     XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     DEPTH    = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_addr,
  input  logic            imem_rsp_valid,
  input  logic [31:0]     imem_rsp_data,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  output logic            id_valid,
  input  logic            id_ready,
  output logic [31:0]     id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned PW = $clog2(DEPTH);
  localparam logic [CW:0]  DEPTH_W = (CW + 1)'(DEPTH);
  localparam logic [31:0]  NOP     = 32'h0000_0013;

  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] redirect_target;

  logic [XLEN-1:0] aq [DEPTH];
  logic [PW-1:0]   aq_rd, aq_wr;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop;

  logic [XLEN-1:0] fifo_pc    [DEPTH];
  logic [31:0]     fifo_instr [DEPTH];
  logic [PW-1:0]   rd_ptr, wr_ptr;
  logic [CW-1:0]   fifo_count;
  logic [XLEN-1:0] last_pc;

  logic            fifo_empty;
  logic            pop;
  logic            push;
  logic            req_fire;
  logic [CW:0]     credit_used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign redirect_target = redirect_pc & ~XLEN'(3);

  assign fifo_empty = (fifo_count == '0);
  assign id_valid   = !fifo_empty && !redirect_valid;
  assign pop        = id_valid && id_ready;
  assign id_instr   = fifo_empty ? NOP : fifo_instr[rd_ptr];
  assign id_pc      = fifo_empty ? last_pc : fifo_pc[rd_ptr];

  // Pending drops stay in outstanding, so they consume credit until they return.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, outstanding} - (CW + 1)'(pop);
  assign imem_req_valid = rst_n && !redirect_valid && (credit_used < DEPTH_W);
  assign imem_addr      = pc;
  assign req_fire       = imem_req_valid && imem_req_ready;
  assign push           = imem_rsp_valid && !redirect_valid && (drop == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc          <= RESET_PC;
      aq_rd       <= '0;
      aq_wr       <= '0;
      outstanding <= '0;
      drop        <= '0;
    end else begin
      if (imem_rsp_valid) aq_rd <= ptr_inc(aq_rd);
      if (redirect_valid) begin
        // Every in-flight request still returns a word; all of them are stale now.
        pc          <= redirect_target;
        drop        <= outstanding - CW'(imem_rsp_valid);
        outstanding <= outstanding - CW'(imem_rsp_valid);
      end else begin
        if (req_fire) begin
          pc    <= pc + XLEN'(4);
          aq_wr <= ptr_inc(aq_wr);
        end
        outstanding <= outstanding + CW'(req_fire) - CW'(imem_rsp_valid);
        if (imem_rsp_valid && (drop != '0)) drop <= drop - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (req_fire) aq[aq_wr] <= pc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      last_pc    <= '0;
    end else begin
      if (!fifo_empty) last_pc <= fifo_pc[rd_ptr];
      if (redirect_valid) begin
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        fifo_count <= '0;
      end else begin
        if (push) wr_ptr <= ptr_inc(wr_ptr);
        if (pop)  rd_ptr <= ptr_inc(rd_ptr);
        fifo_count <= fifo_count + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_pc[wr_ptr]    <= aq[aq_rd];
      fifo_instr[wr_ptr] <= imem_rsp_data;
    end
  end

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
    !(imem_rsp_valid && !redirect_valid && (drop == '0) && (fifo_count == CW'(DEPTH))));

endmodule

// File: tb/tb_riscv_fetch_stage.sv
// Directed and randomized checks of riscv_fetch_stage against an in-order
// imem responder and a fetch-order scoreboard.
module tb_riscv_fetch_stage;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  riscv_fetch_stage #(
    .XLEN     (32),
    .RESET_PC (32'h0000_0000),
    .DEPTH    (2)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_instr       (id_instr),
    .id_pc          (id_pc)
  );

  always #5 clk = ~clk;

  int          n_assert = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  int          lat      = 1;
  bit          rand_lat = 1'b0;
  int          n_req    = 0;
  bit          sb_on    = 1'b0;
  logic [31:0] exp_pc   = '0;
  int          n_deliv  = 0;
  logic [31:0] mq_addr [$];
  int          mq_due  [$];

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Record this cycle's handshakes, advance one clock, then present the next response.
  task automatic step();
    if (rst_n && imem_req_valid && imem_req_ready) begin
      mq_addr.push_back(imem_addr);
      mq_due.push_back(cyc + (rand_lat ? int'($urandom_range(1, 4)) : lat));
      n_req++;
    end
    if (imem_rsp_valid) begin
      void'(mq_addr.pop_front());
      void'(mq_due.pop_front());
    end
    if (sb_on && id_valid && id_ready) begin
      chk("sb_pc", id_pc, exp_pc);
      chk("sb_instr", id_instr, word_of(exp_pc));
      exp_pc += 32'd4;
      n_deliv++;
    end
    if (sb_on && redirect_valid) exp_pc = redirect_pc & ~32'h3;
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && (mq_addr.size() > 0) && (mq_due[0] <= cyc)) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(mq_addr[0]);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
  endtask

  task automatic reset_dut();
    rst_n          = 1'b0;
    imem_rsp_valid = 1'b0;
    redirect_valid = 1'b0;
    mq_addr.delete();
    mq_due.delete();
    #1;
    step();
    step();
  endtask

  initial begin
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    id_ready       = 1'b1;

    // Reset state
    #1 rst_n = 1'b0;
    #2;
    chk("rst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rst_id_valid", 32'(id_valid), 32'd0);
    chk("rst_id_instr", id_instr, 32'h0000_0013);
    chk("rst_imem_addr", imem_addr, 32'h0);
    chk("rst_id_pc", id_pc, 32'h0);
    step();
    step();

    // Streaming, 1-cycle latency
    rst_n = 1'b1;
    for (int k = 0; k < 12; k++) begin
      #1;
      chk("str_req_valid", 32'(imem_req_valid), 32'd1);
      chk("str_addr", imem_addr, 32'(4 * k));
      chk("str_id_valid", 32'(id_valid), 32'(k >= 2));
      if (k >= 2) begin
        chk("str_id_pc", id_pc, 32'(4 * (k - 2)));
        chk("str_id_instr", id_instr, word_of(32'(4 * (k - 2))));
      end
      step();
    end

    // Asynchronous reset mid-cycle while streaming
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_req_valid", 32'(imem_req_valid), 32'd0);
    chk("arst_id_valid", 32'(id_valid), 32'd0);
    chk("arst_id_instr", id_instr, 32'h0000_0013);
    chk("arst_imem_addr", imem_addr, 32'h0);
    reset_dut();

    // Decode backpressure
    id_ready = 1'b0;
    n_req    = 0;
    rst_n    = 1'b1;
    for (int k = 0; k < 10; k++) begin
      #1;
      if (k >= 2) begin
        chk("bp_hold_valid", 32'(id_valid), 32'd1);
        chk("bp_hold_pc", id_pc, 32'h0);
      end
      step();
    end
    #1;
    chk("bp_req_count", 32'(n_req), 32'd2);
    chk("bp_req_valid", 32'(imem_req_valid), 32'd0);
    id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_rel_valid", 32'(id_valid), 32'd1);
      chk("bp_rel_pc", id_pc, 32'(4 * k));
      chk("bp_rel_instr", id_instr, word_of(32'(4 * k)));
      step();
    end

    // Redirect with two requests in flight, 3-cycle latency
    reset_dut();
    lat      = 3;
    id_ready = 1'b1;
    rst_n    = 1'b1;
    #1; step();
    #1; step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0100;
    #1;
    chk("rd_req_valid", 32'(imem_req_valid), 32'd0);
    chk("rd_id_valid", 32'(id_valid), 32'd0);
    step();
    redirect_valid = 1'b0;
    #1;
    chk("rd_addr", imem_addr, 32'h0000_0100);
    chk("rd_credit_block", 32'(imem_req_valid), 32'd0);
    begin
      int w;
      w = 3;
      while (!id_valid && (w < 40)) begin
        step();
        #1;
        w++;
      end
      chk("rd_first_cycle", 32'(w), 32'd8);
      chk("rd_first_pc", id_pc, 32'h0000_0100);
      chk("rd_first_instr", id_instr, word_of(32'h0000_0100));
    end
    step();

    // Misaligned redirect, then wrap at the top of the address space
    reset_dut();
    lat      = 1;
    id_ready = 1'b1;
    rst_n    = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1; step();
    end
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0102;
    #1; step();
    redirect_valid = 1'b0;
    #1;
    chk("ma_addr", imem_addr, 32'h0000_0100);
    chk("ma_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    #1; step();
    #1;
    chk("ma_id_valid", 32'(id_valid), 32'd1);
    chk("ma_id_pc", id_pc, 32'h0000_0100);
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFFC;
    #1; step();
    redirect_valid = 1'b0;
    #1;
    chk("wr_addr_top", imem_addr, 32'hFFFF_FFFC);
    chk("wr_req_valid", 32'(imem_req_valid), 32'd1);
    step();
    #1;
    chk("wr_addr_wrap", imem_addr, 32'h0000_0000);
    step();
    #1;
    chk("wr_id_valid", 32'(id_valid), 32'd1);
    chk("wr_id_pc_top", id_pc, 32'hFFFF_FFFC);
    chk("wr_id_instr_top", id_instr, word_of(32'hFFFF_FFFC));
    step();
    #1;
    chk("wr_id_pc_wrap", id_pc, 32'h0000_0000);
    chk("wr_id_instr_wrap", id_instr, word_of(32'h0000_0000));
    step();

    // Random stress against the fetch-order scoreboard
    reset_dut();
    rand_lat = 1'b1;
    sb_on    = 1'b1;
    exp_pc   = 32'h0;
    n_deliv  = 0;
    rst_n    = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      imem_req_ready = ($urandom_range(0, 3) != 0);
      id_ready       = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom;
      #1;
      step();
    end
    redirect_valid = 1'b0;
    sb_on          = 1'b0;
    #1;
    chk("rnd_progress", 32'(n_deliv > 200), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule
